// File: rtl/video_pkg.sv
// Shared constants, FSM state type and burst address helper for the video line fetcher.
package video_pkg;

   localparam int H_PIXELS         = 1280;
   localparam int BURST_LEN        = 256;
   localparam int AW               = 22;
   localparam int LINE_STRIDE_LOG2 = 12;

   localparam int NUM_BURSTS = H_PIXELS / BURST_LEN;
   localparam int BURST_W    = $clog2(NUM_BURSTS);
   localparam int WORD_W     = $clog2(BURST_LEN);
   localparam int COL_W      = 11;
   localparam int LINE_W     = 10;
   localparam int PIX_W      = 16;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DATA,
      DONE
   } fetch_state_t;

   // Word address of the first word of the given burst within the given line.
   function automatic logic [AW-1:0] burst_addr(input logic [LINE_W-1:0]  line,
                                                input logic [BURST_W-1:0] burst);
      return (AW'(line) << LINE_STRIDE_LOG2) + AW'(burst) * AW'(BURST_LEN);
   endfunction

endpackage

// File: rtl/video_line_fetch_if.sv
// SDRAM controller read port: burst request/ack handshake plus the returned data stream.
interface video_line_fetch_if;
    import video_pkg::*;

    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [PIX_W-1:0]  rd_data;

    modport master (
        output rd_req,
        output rd_addr,
        input  rd_ack,
        input  rd_valid,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        input  rd_addr,
        output rd_ack,
        output rd_valid,
        output rd_data
    );

endinterface

// File: rtl/line_buffer_dp.sv
// Simple dual-port line RAM: one write port, one registered read port, single clock.
module line_buffer_dp #(
    parameter  int DEPTH = 2048,
    parameter  int DW    = 16,
    localparam int ABW   = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           we,
    input  logic [ABW-1:0] wr_addr,
    input  logic [DW-1:0]  wr_data,
    input  logic [ABW-1:0] rd_addr,
    output logic [DW-1:0]  rd_data
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write: a same-address write in this cycle is not visible until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/video_line_fetch.sv
// Fetches one video line from SDRAM in page-sized bursts into the line buffer.
// Define FETCH_PINGPONG_EN for a double-buffered line so scan-out never sees a partial line.
module video_line_fetch
    import video_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_req,
    input  logic [LINE_W-1:0]     line_num,
    output logic                  busy,
    output logic                  line_done,
    output logic                  overrun,
    video_line_fetch_if.master    rd,
    input  logic [COL_W-1:0]      pix_addr,
    output logic [PIX_W-1:0]      pix_data
);

`ifdef FETCH_PINGPONG_EN
    localparam int BUF_DEPTH = 4096;
`else
    localparam int BUF_DEPTH = 2048;
`endif
    localparam int BUF_AW = $clog2(BUF_DEPTH);

    fetch_state_t         state;
    fetch_state_t         next_state;
    logic [LINE_W-1:0]    line_q;
    logic [BURST_W-1:0]   burst_idx;
    logic [WORD_W-1:0]    word_cnt;
    logic                 last_word;
    logic                 last_burst;
    logic                 wr_en;
    logic [COL_W-1:0]     col_wr;
    logic [BUF_AW-1:0]    buf_wr_addr;
    logic [BUF_AW-1:0]    buf_rd_addr;

    assign last_word  = (word_cnt == WORD_W'(BURST_LEN - 1));
    assign last_burst = (burst_idx == BURST_W'(NUM_BURSTS - 1));
    assign col_wr     = COL_W'(burst_idx) * COL_W'(BURST_LEN) + COL_W'(word_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (line_req) next_state = REQ;
            REQ:  if (rd.rd_ack) next_state = DATA;
            DATA: if (rd.rd_valid && last_word) next_state = last_burst ? DONE : REQ;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // rd_addr is zero outside REQ so an idle fetcher presents a quiet bus.
    always_comb begin
        busy       = (state != IDLE);
        line_done  = (state == DONE);
        rd.rd_req  = (state == REQ);
        rd.rd_addr = (state == REQ) ? burst_addr(line_q, burst_idx) : '0;
        wr_en      = (state == DATA) && rd.rd_valid;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_q    <= '0;
            burst_idx <= '0;
            word_cnt  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (state == IDLE && line_req) begin
                line_q    <= line_num;
                burst_idx <= '0;
                word_cnt  <= '0;
            end
            if (line_req && state != IDLE) begin
                overrun <= 1'b1;
            end
            if (wr_en) begin
                word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                if (last_word && !last_burst) begin
                    burst_idx <= burst_idx + 1'b1;
                end
            end
        end
    end

`ifdef FETCH_PINGPONG_EN
    logic wr_sel;

    // The freshly completed bank becomes the scan-out bank as line_done fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_sel <= 1'b0;
        end else if (state == DONE) begin
            wr_sel <= ~wr_sel;
        end
    end

    assign buf_wr_addr = {wr_sel, col_wr};
    assign buf_rd_addr = {~wr_sel, pix_addr};
`else
    assign buf_wr_addr = col_wr;
    assign buf_rd_addr = pix_addr;
`endif

    line_buffer_dp #(
        .DEPTH (BUF_DEPTH),
        .DW    (PIX_W)
    ) u_line_buffer (
        .clk     (clk),
        .reset   (reset),
        .we      (wr_en),
        .wr_addr (buf_wr_addr),
        .wr_data (rd.rd_data),
        .rd_addr (buf_rd_addr),
        .rd_data (pix_data)
    );

endmodule

// File: tb/tb_video_line_fetch.sv
// Directed bench for video_line_fetch with an SDRAM controller model and address/pixel scoreboards.
// Honours FETCH_PINGPONG_EN for the mid-fetch scan-out expectations.
module tb_video_line_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_req = 1'b0;
    logic [9:0]  line_num = '0;
    logic        busy;
    logic        line_done;
    logic        overrun;
    logic [10:0] pix_addr = '0;
    logic [15:0] pix_data;

    video_line_fetch_if rd_bus ();

    video_line_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .line_req  (line_req),
        .line_num  (line_num),
        .busy      (busy),
        .line_done (line_done),
        .overrun   (overrun),
        .rd        (rd_bus),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    int words_sent = 0;
    bit gap_mode = 1'b0;
    logic [21:0] sb_addr [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Controller model: ack three cycles after a request, then stream 256 words (optionally gapped).
    int          cst = 0;
    int          wait_cnt = 0;
    int          word_i = 0;
    int          cyc = 0;
    logic [21:0] cur_addr = '0;

    initial begin : ctrl_model
        rd_bus.rd_ack   = 1'b0;
        rd_bus.rd_valid = 1'b0;
        rd_bus.rd_data  = '0;
        forever begin
            @(negedge clk);
            rd_bus.rd_ack   = 1'b0;
            rd_bus.rd_valid = 1'b0;
            if (reset) begin
                cst = 0;
                words_sent = 0;
            end else begin
                case (cst)
                    0: if (rd_bus.rd_req) begin
                        if (sb_addr.size() == 0) begin
                            checkOutput("spurious_rd_req", 32'(rd_bus.rd_req), 32'd0);
                        end else begin
                            cur_addr = sb_addr.pop_front();
                            checkOutput("rd_addr", 32'(rd_bus.rd_addr), 32'(cur_addr));
                            checkOutput("rd_bank", 32'(rd_bus.rd_addr[9:8]), 32'(int'(cur_addr[11:8]) % 4));
                            wait_cnt = 0;
                            cst = 1;
                        end
                    end
                    1: begin
                        checkOutput("rd_addr_hold", 32'(rd_bus.rd_addr), 32'(cur_addr));
                        wait_cnt++;
                        if (wait_cnt == 2) begin
                            rd_bus.rd_ack = 1'b1;
                            cst = 2;
                        end
                    end
                    2, 3: begin
                        if (cst == 2) begin
                            checkOutput("rd_req_drop", 32'(rd_bus.rd_req), 32'd0);
                            word_i = 0;
                            cyc = 0;
                            cst = 3;
                        end
                        if (!(gap_mode && (cyc % 4 == 3))) begin
                            rd_bus.rd_valid = 1'b1;
                            rd_bus.rd_data  = {cur_addr[16:12], cur_addr[10:0] + 11'(word_i)};
                            word_i++;
                            words_sent++;
                            if (word_i == 256) begin
                                cst = (cur_addr[11:8] == 4'd4) ? 4 : 0;
                            end
                        end
                        cyc++;
                    end
                    4: begin
                        checkOutput("line_done_timing", 32'(line_done), 32'd1);
                        cst = 0;
                    end
                    default: cst = 0;
                endcase
            end
        end
    end

    initial begin : done_monitor
        forever begin
            @(negedge clk);
            if (line_done) begin
                done_count++;
                checkOutput("done_after_1280_words", 32'(words_sent), 32'd1280);
            end
        end
    end

    task automatic applyStimulus(input logic [9:0] ln, input bit gaps);
        for (int b = 0; b < 5; b++) begin
            sb_addr.push_back(22'(int'(ln) * 4096 + b * 256));
        end
        gap_mode = gaps;
        words_sent = 0;
        @(negedge clk);
        line_num = ln;
        line_req = 1'b1;
        @(negedge clk);
        line_req = 1'b0;
        checkOutput("rd_req_rise", 32'(rd_bus.rd_req), 32'd1);
        checkOutput("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic waitDone(input int target);
        int n = 0;
        while (done_count < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("line_done_seen", 32'(done_count), 32'(target));
        checkOutput("addr_sb_drained", 32'(sb_addr.size()), 32'd0);
    endtask

    task automatic waitWords(input int target);
        int n = 0;
        while (words_sent < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("words_reached", 32'(words_sent >= target), 32'd1);
    endtask

    task automatic readLine(input logic [9:0] ln);
        logic [15:0] exp_q [$];
        logic [15:0] e;
        @(negedge clk);
        pix_addr = '0;
        exp_q.push_back({ln[4:0], 11'd0});
        for (int col = 1; col <= 1280; col++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checkOutput("pix_data", 32'(pix_data), 32'(e));
            if (col < 1280) begin
                pix_addr = 11'(col);
                exp_q.push_back({ln[4:0], 11'(col)});
            end
        end
    endtask

    task automatic readOne(input logic [10:0] addr, input logic [15:0] expected, input string tag);
        @(negedge clk);
        pix_addr = addr;
        @(negedge clk);
        checkOutput(tag, 32'(pix_data), 32'(expected));
    endtask

    int done_before;
    logic [15:0] mid_exp;

    initial begin : main
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_line_done", 32'(line_done), 32'd0);
        checkOutput("reset_overrun", 32'(overrun), 32'd0);
        checkOutput("reset_rd_req", 32'(rd_bus.rd_req), 32'd0);
        checkOutput("reset_rd_addr", 32'(rd_bus.rd_addr), 32'd0);
        checkOutput("reset_pix_data", 32'(pix_data), 32'd0);
        reset = 1'b0;

        $display("[TB] line 0, contiguous data");
        applyStimulus(10'd0, 1'b0);
        waitDone(1);
        repeat (5) @(negedge clk);
        checkOutput("single_line_done", 32'(done_count), 32'd1);
        checkOutput("idle_after_done", 32'(busy), 32'd0);
        readLine(10'd0);

        $display("[TB] line 719, top of address range");
        applyStimulus(10'd719, 1'b0);
        waitDone(2);
        readLine(10'd719);

        $display("[TB] line_req during DATA");
        applyStimulus(10'd5, 1'b0);
        waitWords(10);
        @(negedge clk);
        line_num = 10'd9;
        line_req = 1'b1;
        @(negedge clk);
        line_req = 1'b0;
        checkOutput("overrun_set", 32'(overrun), 32'd1);
        waitDone(3);
        repeat (10) @(negedge clk);
        checkOutput("overrun_sticky", 32'(overrun), 32'd1);
        checkOutput("no_extra_rd_req", 32'(rd_bus.rd_req), 32'd0);
        checkOutput("overrun_single_done", 32'(done_count), 32'd3);
        readLine(10'd5);

        $display("[TB] rd_valid gaps");
        applyStimulus(10'd3, 1'b1);
        waitDone(4);
        readLine(10'd3);
        gap_mode = 1'b0;

        $display("[TB] reset mid-fetch");
        applyStimulus(10'd7, 1'b0);
        waitWords(600);
        done_before = done_count;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_rd_req", 32'(rd_bus.rd_req), 32'd0);
        checkOutput("midreset_line_done", 32'(line_done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        sb_addr.delete();
        repeat (20) @(negedge clk);
        checkOutput("midreset_no_done", 32'(done_count), 32'(done_before));
        checkOutput("midreset_overrun_clear", 32'(overrun), 32'd0);
        applyStimulus(10'd2, 1'b0);
        waitDone(done_before + 1);
        readLine(10'd2);

        $display("[TB] scan-out during fetch of next line");
        applyStimulus(10'd0, 1'b0);
        waitDone(done_before + 2);
        applyStimulus(10'd1, 1'b0);
`ifdef FETCH_PINGPONG_EN
        mid_exp = 16'h0005;
`else
        mid_exp = 16'h0805;
`endif
        waitWords(20);
        readOne(11'd5, mid_exp, "midfetch_pix5_early");
        waitWords(700);
        readOne(11'd5, mid_exp, "midfetch_pix5_mid");
        waitWords(1270);
        readOne(11'd5, mid_exp, "midfetch_pix5_late");
        waitDone(done_before + 3);
        readLine(10'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
